prbs23_ber_ctrl: RTL and testbench

BER-test sequencer wrapped around the PRBS23 checker. It issues the checker clear, hunts for descrambler sync and confirms lock. It then runs a measurement window counting tested bits and bit errors from the checker's descrambled output words. Loss of sync forces a re-hunt, and results are latched for software.

---
 rtl/prbs_ctrl_pkg.sv | 39 +++
 rtl/bit_err_popcnt.sv | 26 ++
 rtl/prbs23_ber_ctrl.sv | 148 ++++++++++++++
 tb/tb_prbs23_ber_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_ctrl_pkg.sv
// Shared types and arithmetic helpers for the PRBS23 BER-test sequencer.
package prbs_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    HUNT = 3'd2,
    MEAS = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int unsigned POP_MAX_W = 64;
  localparam int unsigned POP_CNT_W = 7;
  localparam int unsigned SAT_MAX_W = 64;

  // Count set bits among the low w bits of v (callers zero-extend narrower words).
  function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v,
                                                    input int unsigned w);
    logic [POP_CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      if (i < w && v[i]) c = c + POP_CNT_W'(1);
    end
    return c;
  endfunction

  // a + b clamped to the all-ones value of a w-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                   input logic [SAT_MAX_W-1:0] b,
                                                   input int unsigned w);
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (SAT_MAX_W + 1)'(1) << w;
    lim = lim - (SAT_MAX_W + 1)'(1);
    return (sum > lim) ? lim[SAT_MAX_W-1:0] : sum[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/bit_err_popcnt.sv
// Registered count of mismatched bits (zeros) in one checker word.
module bit_err_popcnt
  import prbs_ctrl_pkg::*;
#(
  parameter int unsigned pDAT_W = 8
) (
  input  logic                 iclk,
  input  logic                 irst_n,
  input  logic                 iclkena,
  input  logic                 ival,
  input  logic [pDAT_W-1:0]    idat,
  output logic                 oval,
  output logic [POP_CNT_W-1:0] opop
);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      oval <= 1'b0;
      opop <= '0;
    end else if (iclkena) begin
      oval <= ival;
      opop <= ival ? popcount(POP_MAX_W'(~idat), pDAT_W) : '0;
    end
  end

endmodule

// File: rtl/prbs23_ber_ctrl.sv
// BER-test sequencer around the PRBS23 checker: clear, hunt sync, measure,
// re-hunt on loss of sync, and hold results for software.
module prbs23_ber_ctrl
  import prbs_ctrl_pkg::*;
#(
  parameter int unsigned pDAT_W    = 8,
  parameter int unsigned pSYNC_CNT = 64,
  parameter int unsigned pLOS_CNT  = 16,
  parameter int unsigned pWIN_W    = 32,
  parameter int unsigned pCNT_W    = 48
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              iclkena,
  input  logic              istart,
  input  logic              istop,
  input  logic [pWIN_W-1:0] iwin_len,
  input  logic              ival,
  input  logic [pDAT_W-1:0] idat,
  output logic              ochk_clr,
  output logic              ochk_byp,
  output logic              olock,
  output logic              obusy,
  output logic              odone,
  output logic [pCNT_W-1:0] obit_cnt,
  output logic [pCNT_W-1:0] oerr_cnt,
  output logic [15:0]       olos_cnt,
  output logic [2:0]        ostate
);

  localparam int unsigned SYNC_W  = $clog2(pSYNC_CNT + 1);
  localparam int unsigned LOS_W   = $clog2(pLOS_CNT + 1);
  localparam int unsigned LOSEV_W = 16;

  state_t                state_q, state_d;
  logic [SYNC_W-1:0]     good_q;
  logic [LOS_W-1:0]      bad_q;
  logic [pWIN_W-1:0]     word_q;
  logic                  word_good, meas_word, sync_hit, los_hit, win_hit;
  logic                  acc_vld;
  logic [POP_CNT_W-1:0]  acc_pop;
  logic                  chk_clr_d, byp_d, lock_d, busy_d, done_d;

  assign word_good = &idat;
  assign meas_word = ival && (state_q == MEAS);
  assign sync_hit  = (state_q == HUNT) && ival && word_good &&
                     (good_q == SYNC_W'(pSYNC_CNT - 1));
  assign los_hit   = meas_word && !word_good && (bad_q == LOS_W'(pLOS_CNT - 1));
  assign win_hit   = meas_word && (iwin_len != '0) &&
                     ((word_q + pWIN_W'(1)) == iwin_len);
  assign ostate    = state_q;

  // Error bits arrive one cycle after the word; accumulation follows that pipe.
  bit_err_popcnt #(.pDAT_W(pDAT_W)) u_popcnt (
    .iclk    (iclk),
    .irst_n  (irst_n),
    .iclkena (iclkena),
    .ival    (meas_word),
    .idat    (idat),
    .oval    (acc_vld),
    .opop    (acc_pop)
  );

  always_comb begin
    state_d   = state_q;
    chk_clr_d = 1'b0;
    byp_d     = 1'b0;
    lock_d    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: if (istart) state_d = CLR;
      CLR:  state_d = istop ? DONE : HUNT;
      HUNT: begin
        if (istop)         state_d = DONE;
        else if (sync_hit) state_d = MEAS;
      end
      MEAS: begin
        if (istop)        state_d = DONE;
        else if (win_hit) state_d = DONE;
        else if (los_hit) state_d = HUNT;
      end
      DONE: if (istart) state_d = CLR;
      default: state_d = IDLE;
    endcase
    chk_clr_d = (state_d == CLR);
    byp_d     = (state_d == IDLE);
    lock_d    = (state_d == MEAS);
    busy_d    = (state_d == CLR) || (state_d == HUNT) || (state_d == MEAS);
    done_d    = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q  <= IDLE;
      ochk_clr <= 1'b0;
      ochk_byp <= 1'b1;
      olock    <= 1'b0;
      obusy    <= 1'b0;
      odone    <= 1'b0;
    end else if (iclkena) begin
      state_q  <= state_d;
      ochk_clr <= chk_clr_d;
      ochk_byp <= byp_d;
      olock    <= lock_d;
      obusy    <= busy_d;
      odone    <= done_d;
    end
  end

  // Run counters, window position and the software-visible result counters.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      good_q   <= '0;
      bad_q    <= '0;
      word_q   <= '0;
      obit_cnt <= '0;
      oerr_cnt <= '0;
      olos_cnt <= '0;
    end else if (iclkena) begin
      if (state_q == HUNT && ival)
        good_q <= (word_good && !sync_hit) ? good_q + SYNC_W'(1) : '0;
      else if (state_q != HUNT)
        good_q <= '0;

      if (meas_word)
        bad_q <= (!word_good && !los_hit) ? bad_q + LOS_W'(1) : '0;
      else if (state_q != MEAS)
        bad_q <= '0;

      if (state_q == CLR) begin
        word_q   <= '0;
        obit_cnt <= '0;
        oerr_cnt <= '0;
        olos_cnt <= '0;
      end else begin
        if (meas_word) word_q <= word_q + pWIN_W'(1);
        if (acc_vld) begin
          obit_cnt <= pCNT_W'(sat_add(SAT_MAX_W'(obit_cnt), SAT_MAX_W'(pDAT_W), pCNT_W));
          oerr_cnt <= pCNT_W'(sat_add(SAT_MAX_W'(oerr_cnt), SAT_MAX_W'(acc_pop), pCNT_W));
        end
        if (state_q == MEAS && state_d == HUNT)
          olos_cnt <= LOSEV_W'(sat_add(SAT_MAX_W'(olos_cnt), SAT_MAX_W'(1), LOSEV_W));
      end
    end
  end

endmodule

// File: tb/tb_prbs23_ber_ctrl.sv
// Scoreboard bench for prbs23_ber_ctrl: a 48-bit and an 8-bit counter instance
// share stimulus and are checked against a cycle-level behavioural model.
module tb_prbs23_ber_ctrl;

  localparam int S_IDLE = 0, S_CLR = 1, S_HUNT = 2, S_MEAS = 3, S_DONE = 4;
  localparam int SYNC = 4, LOS = 3;

  typedef struct {
    longint bits;
    longint errs;
    longint los;
  } exp_t;

  logic        iclk = 1'b0, irst_n = 1'b0, iclkena = 1'b1;
  logic        istart = 1'b0, istop = 1'b0, ival = 1'b0;
  logic [31:0] iwin_len = '0;
  logic [7:0]  idat = '0;

  logic        a_clr, a_byp, a_lock, a_busy, a_done;
  logic [47:0] a_bit, a_err;
  logic [15:0] a_los;
  logic [2:0]  a_state;
  logic        b_clr, b_byp, b_lock, b_busy, b_done;
  logic [7:0]  b_bit, b_err;
  logic [15:0] b_los;
  logic [2:0]  b_state;

  int     n_chk = 0, n_err = 0;
  int     m_st = S_IDLE, nst, m_good, m_bad;
  longint m_words, m_bits, m_errs, m_los;
  logic   m_done = 1'b0;
  exp_t   sb_q[$];
  exp_t   cur;
  bit     pend = 0;
  logic [7:0] t2w [10];

  prbs23_ber_ctrl #(.pDAT_W(8), .pSYNC_CNT(SYNC), .pLOS_CNT(LOS), .pWIN_W(32), .pCNT_W(48)) dut (
    .iclk(iclk), .irst_n(irst_n), .iclkena(iclkena), .istart(istart), .istop(istop),
    .iwin_len(iwin_len), .ival(ival), .idat(idat), .ochk_clr(a_clr), .ochk_byp(a_byp),
    .olock(a_lock), .obusy(a_busy), .odone(a_done), .obit_cnt(a_bit), .oerr_cnt(a_err),
    .olos_cnt(a_los), .ostate(a_state));

  prbs23_ber_ctrl #(.pDAT_W(8), .pSYNC_CNT(SYNC), .pLOS_CNT(LOS), .pWIN_W(32), .pCNT_W(8)) u_dut8 (
    .iclk(iclk), .irst_n(irst_n), .iclkena(iclkena), .istart(istart), .istop(istop),
    .iwin_len(iwin_len), .ival(ival), .idat(idat), .ochk_clr(b_clr), .ochk_byp(b_byp),
    .olock(b_lock), .obusy(b_busy), .odone(b_done), .obit_cnt(b_bit), .oerr_cnt(b_err),
    .olos_cnt(b_los), .ostate(b_state));

  always #5 iclk = ~iclk;

  function automatic longint satw(input longint v, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: test sequence rules applied to each enabled cycle.
  always @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      m_st = S_IDLE; m_good = 0; m_bad = 0; m_words = 0;
      m_bits = 0; m_errs = 0; m_los = 0; m_done = 1'b0;
    end else if (iclkena) begin
      nst = m_st;
      case (m_st)
        S_IDLE: if (istart) nst = S_CLR;
        S_CLR: begin
          m_bits = 0; m_errs = 0; m_los = 0; m_words = 0; m_good = 0;
          nst = istop ? S_DONE : S_HUNT;
        end
        S_HUNT: begin
          if (istop) nst = S_DONE;
          else if (ival) begin
            if (idat == 8'hFF) begin
              m_good++;
              if (m_good == SYNC) begin nst = S_MEAS; m_good = 0; m_bad = 0; end
            end else m_good = 0;
          end
        end
        S_MEAS: begin
          if (ival) begin
            m_bits += 8;
            m_errs += 8 - $countones(idat);
            m_words++;
            m_bad = (idat == 8'hFF) ? 0 : m_bad + 1;
          end
          if (istop) nst = S_DONE;
          else if (ival && iwin_len != 0 && m_words == longint'(iwin_len)) nst = S_DONE;
          else if (ival && m_bad == LOS) begin
            m_los++; m_bad = 0; m_good = 0; nst = S_HUNT;
          end
        end
        S_DONE: if (istart) nst = S_CLR;
        default: nst = S_IDLE;
      endcase
      m_done = (nst == S_DONE) && (m_st != S_DONE);
      if (m_done) sb_q.push_back('{m_bits, m_errs, m_los});
      m_st = nst;
    end
  end

  function automatic logic [8:0] exp_flags();
    return {3'(m_st), m_st == S_CLR, m_st == S_IDLE, m_st == S_MEAS,
            (m_st == S_CLR || m_st == S_HUNT || m_st == S_MEAS), m_done};
  endfunction

  // Monitor: per-cycle control outputs, and result counters once DONE settles.
  initial forever begin
    @(negedge iclk);
    if (pend) begin
      pend = 0;
      check("done_bits48", 64'(a_bit), 64'(satw(cur.bits, 48)));
      check("done_errs48", 64'(a_err), 64'(satw(cur.errs, 48)));
      check("done_los48",  64'(a_los), 64'(satw(cur.los, 16)));
      check("done_bits8",  64'(b_bit), 64'(satw(cur.bits, 8)));
      check("done_errs8",  64'(b_err), 64'(satw(cur.errs, 8)));
      check("done_los8",   64'(b_los), 64'(satw(cur.los, 16)));
    end
    check("flags48", 64'({a_state, a_clr, a_byp, a_lock, a_busy, a_done}), 64'(exp_flags()));
    check("flags8",  64'({b_state, b_clr, b_byp, b_lock, b_busy, b_done}), 64'(exp_flags()));
    if (a_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL done_pop: odone=1 with no expected DONE entry at %0t", $time);
      end else begin
        cur = sb_q.pop_front();
        pend = 1;
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic st, input logic sp);
    ival = v; idat = d; istart = st; istop = sp;
    @(negedge iclk);
    ival = 1'b0; istart = 1'b0; istop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic sync_up();
    for (int i = 0; i < 64 && a_state != 3'd3; i++) drive(1'b1, 8'hFF, 1'b0, 1'b0);
    check("sync_lock", 64'(a_state), 64'd3);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && a_state != 3'd4; i++) idle(1);
    check("reach_done", 64'(a_state), 64'd4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t2w = '{8'hFF, 8'hFE, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    idle(3);
    check("rst_bits", 64'(a_bit), 64'd0);
    check("rst_errs", 64'(a_err), 64'd0);
    check("rst_byp",  64'(a_byp), 64'd1);
    irst_n = 1'b1;
    idle(2);

    // Window of 10 clean words
    iwin_len = 10;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("clr_pulse", 64'(a_clr), 64'd1);
    sync_up();
    repeat (10) drive(1'b1, 8'hFF, 1'b0, 1'b0);
    wait_done(5);
    idle(3);
    check("t1_bits", 64'(a_bit), 64'd80);
    check("t1_errs", 64'(a_err), 64'd0);

    // Window with 9 bit errors
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    sync_up();
    for (int i = 0; i < 10; i++) drive(1'b1, t2w[i], 1'b0, 1'b0);
    wait_done(5);
    idle(3);
    check("t2_bits", 64'(a_bit), 64'd80);
    check("t2_errs", 64'(a_err), 64'd9);

    // Loss of sync and re-lock, open window, stop
    iwin_len = 0;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    sync_up();
    repeat (5) drive(1'b1, 8'hFF, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 8'h7F, 1'b0, 1'b0);
    check("t3_hunt", 64'(a_state), 64'd2);
    check("t3_los",  64'(a_los), 64'd1);
    sync_up();
    repeat (5) drive(1'b1, 8'hFF, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    wait_done(5);
    idle(3);
    check("t3_bits", 64'(a_bit), 64'd104);
    check("t3_errs", 64'(a_err), 64'd3);

    // Long run until stop; 8-bit instance must saturate
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    sync_up();
    repeat (1000) drive(1'b1, 8'hFF, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    wait_done(5);
    idle(3);
    check("t4_bits48", 64'(a_bit), 64'd8000);
    check("t6_bits8",  64'(b_bit), 64'd255);
    check("t6_errs8",  64'(b_err), 64'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) drive(1'b1, 8'hFF, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    wait_done(3);
    idle(3);
    check("t4_startstop_bits", 64'(a_bit), 64'd0);

    // Clock-enable freeze, then reset mid-measurement
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    sync_up();
    repeat (5) drive(1'b1, 8'hFF, 1'b0, 1'b0);
    idle(2);
    check("t5_pre_bits", 64'(a_bit), 64'd40);
    iclkena = 1'b0;
    repeat (5) drive(1'b1, 8'h00, 1'b0, 1'b0);
    iclkena = 1'b1;
    idle(2);
    check("t5_frz_bits",  64'(a_bit), 64'd40);
    check("t5_frz_errs",  64'(a_err), 64'd0);
    check("t5_frz_state", 64'(a_state), 64'd3);
    repeat (2) drive(1'b1, 8'h0F, 1'b0, 1'b0);
    #2 irst_n = 1'b0;
    #1;
    check("t5_rst_state", 64'(a_state), 64'd0);
    check("t5_rst_byp",   64'(a_byp), 64'd1);
    check("t5_rst_done",  64'(a_done), 64'd0);
    check("t5_rst_lock",  64'(a_lock), 64'd0);
    check("t5_rst_bits",  64'(a_bit), 64'd0);
    check("t5_rst_errs",  64'(a_err), 64'd0);
    @(negedge iclk);
    idle(2);
    irst_n = 1'b1;
    idle(2);

    // Randomized sessions
    for (int r = 0; r < 25; r++) begin
      iwin_len = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(5, 40));
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      for (int c = 0; c < 300 && m_st != S_DONE; c++) begin
        logic v, st, sp;
        logic [7:0] d;
        v = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: d = 8'hFF;
          6, 7:             d = ~(8'h01 << $urandom_range(0, 7));
          default:          d = 8'($urandom);
        endcase
        st = ($urandom_range(0, 49) == 0);
        sp = (iwin_len == 0) ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 299) == 0);
        drive(v, d, st, sp);
      end
      if (m_st != S_DONE) drive(1'b0, 8'h00, 1'b0, 1'b1);
      idle(4);
    end

    idle(4);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("sb_pend",  64'(pend), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
